controle_player: RTL and testbench
==================================

CONTROLE_PLAYER -- requirements
Module: controle_player

Interface
REQ-001 Parameter NUM_FAIXAS, default 8: number of tracks; range 2..256.
REQ-002 Parameter CICLOS_POR_SEG, default 50_000_000: clock cycles per playback second; minimum 2.
REQ-003 Parameter DURACAO_FAIXA, default 180: seconds per track; range 1..255.
REQ-004 Parameter LOCK_CICLOS, default 1000: remote-lockout cycles after an accepted local command; minimum 1.
REQ-005 clock_in  in  1  single clock; all logic on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 play_pulso_L, selecao_pulso_L, stop_pulso_L  in  1 each  one-cycle local command pulses.
REQ-008 mute_pulso_R, play_pulso_R, selecao_pulso_R, stop_pulso_R  in  1 each  one-cycle remote command pulses.
REQ-009 estado  out  2  00 PARADO, 01 TOCANDO, 10 PAUSADO; 11 never driven.
REQ-010 faixa  out  clog2(NUM_FAIXAS)  current track index.
REQ-011 tempo_seg  out  8  elapsed seconds in the current track.
REQ-012 mute  out  1  1 = audio muted.
REQ-013 cmd_aceito  out  1  one-cycle pulse when a play/selecao/stop command is accepted.
REQ-014 origem_remota  out  1  source of the last accepted command; 1 = remote; held until the next accepted command.

Function
REQ-015 All outputs SHALL be registered; an accepted command SHALL be visible on outputs exactly 1 cycle after its pulse cycle.
REQ-016 Arbitration: if any local play/selecao/stop pulse is high, the local command wins and remote play/selecao/stop pulses in that cycle SHALL be discarded.
REQ-017 Within one source: stop > play > selecao; lower-priority pulses in the same cycle SHALL be discarded.
REQ-018 Lockout: an accepted local command SHALL load a counter with LOCK_CICLOS; while it is nonzero, remote play/selecao/stop SHALL be ignored; it decrements each cycle to 0.
REQ-019 mute_pulso_R SHALL toggle mute in any state and cycle, with no lockout or arbitration, and SHALL NOT assert cmd_aceito.
REQ-020 play: PARADO->TOCANDO with tempo_seg=0 and prescaler=0; TOCANDO->PAUSADO; PAUSADO->TOCANDO with tempo_seg and prescaler held.
REQ-021 stop: any state->PARADO, tempo_seg=0, prescaler=0; faixa unchanged; accepted in PARADO too.
REQ-022 selecao: accepted only in PARADO; faixa=(faixa+1) mod NUM_FAIXAS. In TOCANDO/PAUSADO it SHALL be ignored, with no cmd_aceito, no origem change and no lockout load.
REQ-023 Prescaler: in TOCANDO it counts 0..CICLOS_POR_SEG-1; on wrap, tempo_seg increments. It SHALL be frozen in PAUSADO and held at 0 in PARADO.
REQ-024 End of track: on a prescaler wrap with tempo_seg==DURACAO_FAIXA-1:
- if faixa<NUM_FAIXAS-1: faixa+1, tempo_seg=0, stay TOCANDO;
- else: faixa=0, tempo_seg=0, ->PARADO.
REQ-025 An accepted command in the same cycle as an end-of-track wrap SHALL take precedence; the auto-advance SHALL be discarded.
REQ-026 cmd_aceito SHALL be 0 in every cycle with no accepted command.

Reset
REQ-027 reset SHALL force estado=PARADO, faixa=0, tempo_seg=0, mute=0, cmd_aceito=0, origem_remota=0, prescaler=0, lockout=0 on the next edge, overriding any simultaneous pulse.
REQ-028 A reset asserted mid-playback or mid-lockout SHALL leave no residual state; the first cycle after deassertion SHALL accept commands normally.

Structure
REQ-029 The estado encodings (PARADO/TOCANDO/PAUSADO) SHALL live in a shared definitions file, controle_player_defs, for reuse by display logic.
REQ-030 Arbitration and lockout (REQ-016..018) SHALL be one sub-module, arbitro_comandos. It outputs a winning command (none/play/selecao/stop) and its source. The FSM, prescaler and counters stay in controle_player.

Verification (bench params: NUM_FAIXAS=4, CICLOS_POR_SEG=4, DURACAO_FAIXA=3, LOCK_CICLOS=5)
REQ-031 Reset, then play_pulso_L at cycle 10 -> estado=01 at cycle 11, cmd_aceito=1 for 1 cycle, origem_remota=0; tempo_seg=1 after 4 more cycles.
REQ-032 play_pulso_L and stop_pulso_R in the same cycle -> local play wins; stop_pulso_R 3 cycles later is ignored (lockout); stop_pulso_R 6 cycles after the play -> estado=00, origem_remota=1.
REQ-033 From PARADO, faixa=3: selecao_pulso_R -> faixa=0. In TOCANDO, selecao_pulso_L -> faixa unchanged, cmd_aceito stays 0.
REQ-034 Play at faixa=2, no pulses for 12 cycles -> faixa=3, tempo_seg=0, TOCANDO. After 12 more cycles -> estado=00, faixa=0.
REQ-035 In TOCANDO: play pauses with tempo_seg=1 held for 20 cycles; play resumes from 1; mute_pulso_R in the same cycle as play_pulso_L -> mute=1 and play accepted.
REQ-036 reset during lockout with tempo_seg=2 -> all outputs at reset values; play_pulso_R on the first post-reset cycle is accepted.

Source files
------------

// File: rtl/controle_player_defs.sv
// Shared definitions for the player: playback state and command codes.
// estado_e is reused by display logic, cmd_e by the arbiter and FSM.
package controle_player_defs;

  typedef enum logic [1:0] {
    PARADO  = 2'b00,
    TOCANDO = 2'b01,
    PAUSADO = 2'b10
  } estado_e;

  typedef enum logic [1:0] {
    CMD_NONE = 2'b00,
    CMD_PLAY = 2'b01,
    CMD_SEL  = 2'b10,
    CMD_STOP = 2'b11
  } cmd_e;

endpackage

// File: rtl/controle_player_if.sv
// Command pulses (local _L, remote _R) and player status outputs.
// master: pulse source / status reader; slave: the player.
interface controle_player_if #(
  parameter int NUM_FAIXAS = 8
) ();
  localparam int FW = $clog2(NUM_FAIXAS);

  logic          play_pulso_L;
  logic          selecao_pulso_L;
  logic          stop_pulso_L;
  logic          mute_pulso_R;
  logic          play_pulso_R;
  logic          selecao_pulso_R;
  logic          stop_pulso_R;
  logic [1:0]    estado;
  logic [FW-1:0] faixa;
  logic [7:0]    tempo_seg;
  logic          mute;
  logic          cmd_aceito;
  logic          origem_remota;

  modport master (
    output play_pulso_L, selecao_pulso_L, stop_pulso_L,
    output mute_pulso_R, play_pulso_R, selecao_pulso_R,
    output stop_pulso_R,
    input  estado, faixa, tempo_seg, mute, cmd_aceito,
    input  origem_remota
  );

  modport slave (
    input  play_pulso_L, selecao_pulso_L, stop_pulso_L,
    input  mute_pulso_R, play_pulso_R, selecao_pulso_R,
    input  stop_pulso_R,
    output estado, faixa, tempo_seg, mute, cmd_aceito,
    output origem_remota
  );
endinterface

// File: rtl/arbitro_comandos.sv
// Picks the winning command of the cycle (local beats remote,
// stop > play > selecao) and holds the remote lockout counter.
// Ports: clock_in/reset, local and remote pulses, sel_ok_i
// (selecao is legal now), cmd_o winning command, remoto_o source.
import controle_player_defs::*;

module arbitro_comandos #(
  parameter int LOCK_CICLOS = 1000
) (
  input  logic clock_in,
  input  logic reset,
  input  logic play_l_i,
  input  logic sel_l_i,
  input  logic stop_l_i,
  input  logic play_r_i,
  input  logic sel_r_i,
  input  logic stop_r_i,
  input  logic sel_ok_i,
  output cmd_e cmd_o,
  output logic remoto_o
);
  localparam int LW = $clog2(LOCK_CICLOS + 1);

  logic [LW-1:0] lock_q, lock_d;
  logic          local_any;

  assign local_any = play_l_i | sel_l_i | stop_l_i;

  // Any local pulse silences the remote side, even a local
  // selecao that ends up ignored outside PARADO.
  always_comb begin
    cmd_o    = CMD_NONE;
    remoto_o = 1'b0;
    if (local_any) begin
      if (stop_l_i)
        cmd_o = CMD_STOP;
      else if (play_l_i)
        cmd_o = CMD_PLAY;
      else if (sel_ok_i)
        cmd_o = CMD_SEL;
    end else if (lock_q == '0) begin
      if (stop_r_i)
        cmd_o = CMD_STOP;
      else if (play_r_i)
        cmd_o = CMD_PLAY;
      else if (sel_r_i && sel_ok_i)
        cmd_o = CMD_SEL;
      remoto_o = (cmd_o != CMD_NONE);
    end
  end

  always_comb begin
    lock_d = lock_q;
    if (cmd_o != CMD_NONE && !remoto_o)
      lock_d = LW'(LOCK_CICLOS);
    else if (lock_q != '0)
      lock_d = lock_q - 1'b1;
  end

  always_ff @(posedge clock_in) begin
    if (reset)
      lock_q <= '0;
    else
      lock_q <= lock_d;
  end
endmodule

// File: rtl/controle_player.sv
// Track player: play/pause/stop FSM, per-second prescaler, elapsed
// time and track counters, mute toggle. Ports: clock_in, reset, bus.
import controle_player_defs::*;

module controle_player #(
  parameter int NUM_FAIXAS     = 8,
  parameter int CICLOS_POR_SEG = 50_000_000,
  parameter int DURACAO_FAIXA  = 180,
  parameter int LOCK_CICLOS    = 1000
) (
  input  logic               clock_in,
  input  logic               reset,
  controle_player_if.slave   bus
);
  localparam int FW = $clog2(NUM_FAIXAS);
  localparam int PW = $clog2(CICLOS_POR_SEG);
  localparam logic [FW-1:0] F_LAST = FW'(NUM_FAIXAS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(CICLOS_POR_SEG - 1);
  localparam logic [7:0]    T_LAST = 8'(DURACAO_FAIXA - 1);

  estado_e       estado_q;
  logic [FW-1:0] faixa_q;
  logic [7:0]    tempo_q;
  logic [PW-1:0] presc_q;
  logic          mute_q;
  logic          cmd_q;
  logic          orig_q;
  cmd_e          cmd;
  logic          remoto;

  arbitro_comandos #(
    .LOCK_CICLOS(LOCK_CICLOS)
  ) u_arb (
    .clock_in (clock_in),
    .reset    (reset),
    .play_l_i (bus.play_pulso_L),
    .sel_l_i  (bus.selecao_pulso_L),
    .stop_l_i (bus.stop_pulso_L),
    .play_r_i (bus.play_pulso_R),
    .sel_r_i  (bus.selecao_pulso_R),
    .stop_r_i (bus.stop_pulso_R),
    .sel_ok_i (estado_q == PARADO),
    .cmd_o    (cmd),
    .remoto_o (remoto)
  );

  always_ff @(posedge clock_in) begin
    if (reset) begin
      estado_q <= PARADO;
      faixa_q  <= '0;
      tempo_q  <= '0;
      presc_q  <= '0;
      mute_q   <= 1'b0;
      cmd_q    <= 1'b0;
      orig_q   <= 1'b0;
    end else begin
      cmd_q <= (cmd != CMD_NONE);
      if (cmd != CMD_NONE)
        orig_q <= remoto;
      if (bus.mute_pulso_R)
        mute_q <= ~mute_q;
      // A command wins over a same-cycle end-of-track wrap.
      unique case (cmd)
        CMD_STOP: begin
          estado_q <= PARADO;
          tempo_q  <= '0;
          presc_q  <= '0;
        end
        CMD_PLAY: begin
          unique case (estado_q)
            PARADO: begin
              estado_q <= TOCANDO;
              tempo_q  <= '0;
              presc_q  <= '0;
            end
            TOCANDO: estado_q <= PAUSADO;
            default: estado_q <= TOCANDO;
          endcase
        end
        CMD_SEL: begin
          faixa_q <= (faixa_q == F_LAST) ? '0 : faixa_q + 1'b1;
        end
        default: begin
          if (estado_q == TOCANDO) begin
            if (presc_q == P_LAST) begin
              presc_q <= '0;
              if (tempo_q == T_LAST) begin
                tempo_q <= '0;
                if (faixa_q == F_LAST) begin
                  faixa_q  <= '0;
                  estado_q <= PARADO;
                end else begin
                  faixa_q <= faixa_q + 1'b1;
                end
              end else begin
                tempo_q <= tempo_q + 1'b1;
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign bus.estado        = estado_q;
  assign bus.faixa         = faixa_q;
  assign bus.tempo_seg     = tempo_q;
  assign bus.mute          = mute_q;
  assign bus.cmd_aceito    = cmd_q;
  assign bus.origem_remota = orig_q;
endmodule

// File: tb/tb_controle_player.sv
// Directed bench for controle_player: vector table plus hand-written
// multi-cycle sequences (timing, lockout, end of track, pause, reset).
module tb_controle_player;
  localparam int NF = 4;

  localparam logic [7:0] RST = 8'h80;
  localparam logic [7:0] PL  = 8'h40;
  localparam logic [7:0] SL  = 8'h20;
  localparam logic [7:0] TL  = 8'h10;
  localparam logic [7:0] MR  = 8'h08;
  localparam logic [7:0] PR  = 8'h04;
  localparam logic [7:0] SR  = 8'h02;
  localparam logic [7:0] TR  = 8'h01;

  typedef struct {
    logic [7:0] in;
    logic [1:0] e;
    logic [1:0] f;
    logic [7:0] t;
    logic       m;
    logic       c;
    logic       o;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_fail = 0;
  vec_t vq[$];

  controle_player_if #(.NUM_FAIXAS(NF)) bus ();

  controle_player #(
    .NUM_FAIXAS    (NF),
    .CICLOS_POR_SEG(4),
    .DURACAO_FAIXA (3),
    .LOCK_CICLOS   (5)
  ) dut (
    .clock_in(clk),
    .reset   (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string n, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask

  task automatic chk(input string n, input logic [1:0] e,
                     input logic [1:0] f, input logic [7:0] t,
                     input logic m, input logic c, input logic o);
    cmp({n, ".estado"}, int'(bus.estado), int'(e));
    cmp({n, ".faixa"}, int'(bus.faixa), int'(f));
    cmp({n, ".tempo_seg"}, int'(bus.tempo_seg), int'(t));
    cmp({n, ".mute"}, int'(bus.mute), int'(m));
    cmp({n, ".cmd_aceito"}, int'(bus.cmd_aceito), int'(c));
    cmp({n, ".origem"}, int'(bus.origem_remota), int'(o));
  endtask

  // Apply one cycle of inputs, sample 1 time unit after the edge.
  task automatic cyc(input logic [7:0] p);
    @(negedge clk);
    rst                 = p[7];
    bus.play_pulso_L    = p[6];
    bus.selecao_pulso_L = p[5];
    bus.stop_pulso_L    = p[4];
    bus.mute_pulso_R    = p[3];
    bus.play_pulso_R    = p[2];
    bus.selecao_pulso_R = p[1];
    bus.stop_pulso_R    = p[0];
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(8'h00);
  endtask

  initial begin
    rst = 1'b1;
    bus.play_pulso_L    = 1'b0;
    bus.selecao_pulso_L = 1'b0;
    bus.stop_pulso_L    = 1'b0;
    bus.mute_pulso_R    = 1'b0;
    bus.play_pulso_R    = 1'b0;
    bus.selecao_pulso_R = 1'b0;
    bus.stop_pulso_R    = 1'b0;

    //            in          e  f  t  m  c  o
    vq.push_back('{RST,       0, 0, 0, 0, 0, 0});
    vq.push_back('{SL,        0, 1, 0, 0, 1, 0});
    vq.push_back('{SR,        0, 1, 0, 0, 0, 0});
    vq.push_back('{MR,        0, 1, 0, 1, 0, 0});
    vq.push_back('{TL,        0, 1, 0, 1, 1, 0});
    vq.push_back('{PL|SL,     1, 1, 0, 1, 1, 0});
    vq.push_back('{8'h00,     1, 1, 0, 1, 0, 0});
    vq.push_back('{SL,        1, 1, 0, 1, 0, 0});
    vq.push_back('{8'h00,     1, 1, 0, 1, 0, 0});
    vq.push_back('{8'h00,     1, 1, 1, 1, 0, 0});
    vq.push_back('{8'h00,     1, 1, 1, 1, 0, 0});
    vq.push_back('{PR,        2, 1, 1, 1, 1, 1});
    vq.push_back('{8'h00,     2, 1, 1, 1, 0, 1});
    vq.push_back('{TL|PR,     0, 1, 0, 1, 1, 0});
    vq.push_back('{RST|PL,    0, 0, 0, 0, 0, 0});
    vq.push_back('{PR,        1, 0, 0, 0, 1, 1});
    vq.push_back('{TR|PR|SR,  0, 0, 0, 0, 1, 1});
    vq.push_back('{PR|SR,     1, 0, 0, 0, 1, 1});
    vq.push_back('{TR,        0, 0, 0, 0, 1, 1});
    vq.push_back('{SR,        0, 1, 0, 0, 1, 1});
    vq.push_back('{MR|TR,     0, 1, 0, 1, 1, 1});

    foreach (vq[i]) begin
      cyc(vq[i].in);
      chk($sformatf("v%0d", i), vq[i].e, vq[i].f, vq[i].t,
          vq[i].m, vq[i].c, vq[i].o);
    end

    // Play at cycle 10 after reset; one second is 4 cycles.
    cyc(RST);
    idle(9);
    cyc(PL);
    chk("a_play", 1, 0, 0, 0, 1, 0);
    cyc(8'h00);
    chk("a_pulse", 1, 0, 0, 0, 0, 0);
    idle(2);
    chk("a_t0", 1, 0, 0, 0, 0, 0);
    cyc(8'h00);
    chk("a_t1", 1, 0, 1, 0, 0, 0);

    // Local beats remote; lockout window of 5 cycles.
    cyc(RST);
    cyc(PL | TR);
    chk("b_arb", 1, 0, 0, 0, 1, 0);
    idle(2);
    cyc(TR);
    chk("b_lock", 1, 0, 0, 0, 0, 0);
    idle(2);
    cyc(TR);
    chk("b_free", 0, 0, 0, 0, 1, 1);

    // Track wrap by selecao; selecao ignored while playing.
    cyc(RST);
    cyc(SL);
    cyc(SL);
    cyc(SL);
    chk("c_f3", 0, 3, 0, 0, 1, 0);
    idle(5);
    cyc(SR);
    chk("c_wrap", 0, 0, 0, 0, 1, 1);
    cyc(PL);
    chk("c_play", 1, 0, 0, 0, 1, 0);
    cyc(SL);
    chk("c_selign", 1, 0, 0, 0, 0, 0);

    // End of track advance, then end of last track stops.
    cyc(RST);
    cyc(SL);
    cyc(SL);
    cyc(PL);
    chk("d_play", 1, 2, 0, 0, 1, 0);
    idle(11);
    chk("d_pre", 1, 2, 2, 0, 0, 0);
    cyc(8'h00);
    chk("d_adv", 1, 3, 0, 0, 0, 0);
    idle(11);
    chk("d_pre2", 1, 3, 2, 0, 0, 0);
    cyc(8'h00);
    chk("d_end", 0, 0, 0, 0, 0, 0);

    // Pause holds time and prescaler; mute alongside play.
    cyc(RST);
    cyc(PL);
    idle(4);
    chk("e_t1", 1, 0, 1, 0, 0, 0);
    cyc(PL);
    chk("e_pause", 2, 0, 1, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(8'h00);
      chk($sformatf("e_hold%0d", i), 2, 0, 1, 0, 0, 0);
    end
    cyc(PL | MR);
    chk("e_resume", 1, 0, 1, 1, 1, 0);
    idle(3);
    chk("e_r3", 1, 0, 1, 1, 0, 0);
    cyc(8'h00);
    chk("e_t2", 1, 0, 2, 1, 0, 0);

    // Reset during lockout with tempo_seg=2.
    cyc(RST);
    cyc(MR);
    cyc(PL);
    idle(8);
    chk("f_t2", 1, 0, 2, 1, 0, 0);
    cyc(PL);
    chk("f_lock", 2, 0, 2, 1, 1, 0);
    cyc(RST | PR);
    chk("f_rst", 0, 0, 0, 0, 0, 0);
    cyc(PR);
    chk("f_post", 1, 0, 0, 0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
